// File: rtl/name_sprite_renderer_pkg.sv
// Shared constants, FSM encoding and address helper for the name banner sprite renderer.
package name_sprite_renderer_pkg;

    localparam int unsigned SPR_W          = 356;
    localparam int unsigned SPR_H          = 12;
    localparam int unsigned ROM_AW         = 13;
    localparam int unsigned ROM_DEPTH      = 4272;
    localparam int unsigned X0             = 142;
    localparam int unsigned Y0             = 60;
    localparam int unsigned COLS_PER_FRAME = 4;
    localparam logic [7:0]  TRANSP_KEY     = 8'h00;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_REVEAL = 2'd1;
    localparam state_t ST_SHOWN  = 2'd2;

    // row * 356 as shift-add: 356 = 256 + 64 + 32 + 4
    function automatic logic [ROM_AW-1:0] row_base(input logic [3:0] row);
        logic [ROM_AW-1:0] r;
        r = {9'd0, row};
        return (r << 4'd8) + (r << 4'd6) + (r << 4'd5) + (r << 4'd2);
    endfunction

endpackage

// File: rtl/name_reveal_ctrl.sv
// Reveal FSM with saturating column counter for the name banner sprite.
module name_reveal_ctrl
    import name_sprite_renderer_pkg::*;
(
    input  logic       i_clk2,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_frame_tick,
    output logic [8:0] reveal_cols,
    output logic       o_done
);

    state_t     state_r;
    logic [8:0] cols_r;
    logic       done_r;
    logic [9:0] sum_s;
    logic [8:0] cols_next_s;

    // Next reveal width, clamped to the sprite width
    always_comb begin
        sum_s = {1'b0, cols_r} + 10'(COLS_PER_FRAME);
        if (sum_s >= 10'(SPR_W)) begin
            cols_next_s = 9'(SPR_W);
        end else begin
            cols_next_s = sum_s[8:0];
        end
    end

    // FSM and counter; a start pulse always wins over a frame tick
    always_ff @(posedge i_clk2) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            cols_r  <= 9'd0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        state_r <= ST_REVEAL;
                        cols_r  <= 9'd0;
                    end
                end
                ST_REVEAL: begin
                    if (i_start) begin
                        cols_r <= 9'd0;
                    end else if (i_frame_tick) begin
                        cols_r <= cols_next_s;
                        if (cols_next_s == 9'(SPR_W)) begin
                            state_r <= ST_SHOWN;
                            done_r  <= 1'b1;
                        end
                    end
                end
                ST_SHOWN: begin
                    if (i_start) begin
                        state_r <= ST_REVEAL;
                        cols_r  <= 9'd0;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cols_r  <= 9'd0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign reveal_cols = cols_r;
    assign o_done      = done_r;

endmodule

// File: rtl/name_sprite_renderer.sv
// Name banner sprite read engine: scan position -> ROM address -> aligned pixel/hit.
// Optional reveal animation enabled by defining NAME_REVEAL_EN.
module name_sprite_renderer
    import name_sprite_renderer_pkg::*;
(
    input  logic              i_clk2,
    input  logic              i_rst,
    input  logic [9:0]        i_x,
    input  logic [9:0]        i_y,
    input  logic              i_de,
    input  logic              i_frame_tick,
    input  logic              i_start,
    output logic [ROM_AW-1:0] o_rom_addr,
    input  logic [7:0]        i_rom_data,
    output logic [7:0]        o_pixel,
    output logic              o_hit,
    output logic              o_done
);

    logic              in_s;
    logic [8:0]        col_s;
    logic [3:0]        row_s;
    logic [8:0]        reveal_cols_s;
    logic              done_s;
    logic [ROM_AW-1:0] addr_r;
    logic              vis_d1_r;
    logic              vis_d2_r;
    logic [7:0]        pixel_r;
    logic              hit_r;

    // Stage A window test and sprite-local coordinates
    always_comb begin
        in_s  = i_de
              && (i_x >= 10'(X0)) && (i_x < 10'(X0 + SPR_W))
              && (i_y >= 10'(Y0)) && (i_y < 10'(Y0 + SPR_H));
        col_s = 9'(i_x - 10'(X0));
        row_s = 4'(i_y - 10'(Y0));
    end

`ifdef NAME_REVEAL_EN
    name_reveal_ctrl u_reveal_ctrl (
        .i_clk2       (i_clk2),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_frame_tick (i_frame_tick),
        .reveal_cols  (reveal_cols_s),
        .o_done       (done_s)
    );
`else
    logic shown_r;
    logic unused_tick_s;

    // Without the animation a start pulse shows the whole sprite at once
    always_ff @(posedge i_clk2) begin
        if (i_rst) begin
            shown_r <= 1'b0;
        end else if (i_start) begin
            shown_r <= 1'b1;
        end
    end

    assign reveal_cols_s = shown_r ? 9'(SPR_W) : 9'd0;
    assign done_s        = shown_r;
    assign unused_tick_s = i_frame_tick;
`endif

    // Address/visibility pipeline aligned to the 1-cycle ROM read
    always_ff @(posedge i_clk2) begin
        if (i_rst) begin
            addr_r   <= '0;
            vis_d1_r <= 1'b0;
            vis_d2_r <= 1'b0;
            pixel_r  <= 8'h00;
            hit_r    <= 1'b0;
        end else begin
            if (in_s) begin
                addr_r <= row_base(row_s) + {4'd0, col_s};
            end
            vis_d1_r <= in_s && (col_s < reveal_cols_s);
            vis_d2_r <= vis_d1_r;
            if (vis_d2_r) begin
                pixel_r <= i_rom_data;
                hit_r   <= (i_rom_data != TRANSP_KEY);
            end else begin
                pixel_r <= 8'h00;
                hit_r   <= 1'b0;
            end
        end
    end

    assign o_rom_addr = addr_r;
    assign o_pixel    = pixel_r;
    assign o_hit      = hit_r;
    assign o_done     = done_s;

endmodule

// File: doc/name_sprite_renderer.md
# name_sprite_renderer

Read-side engine for the 356x12 "name" banner sprite ROM (8-bit pixels, 4272 words, 1-cycle registered read). It takes the VGA scan position, generates the ROM address, and aligns the returned pixel to the scan pipeline. It applies a transparency key and a left-to-right column reveal animation, and outputs a pixel plus a hit flag to the VGA colour mux.

## Interface
- SPR_W, 356, sprite width in pixels
- SPR_H, 12, sprite height in pixels
- X0, 142, screen x of sprite's left column
- Y0, 60, screen y of sprite's top row
- COLS_PER_FRAME, 4, columns revealed per frame tick
- TRANSP_KEY, 8'h00, pixel value treated as transparent
- i_clk2 in 1 pixel clock; all logic on posedge
- i_rst in 1 synchronous, active-high reset
- i_x in 10 current scan column
- i_y in 10 current scan row
- i_de in 1 active-video qualifier for i_x/i_y
- i_frame_tick in 1 one-cycle pulse per frame (start of vblank)
- i_start in 1 one-cycle pulse: begin reveal
- o_rom_addr out 13 address to sprite ROM
- i_rom_data in 8 ROM data, valid one cycle after o_rom_addr
- o_pixel out 8 pixel value, aligned with o_hit
- o_hit out 1 pixel is inside the sprite, revealed and non-transparent
- o_done out 1 reveal complete (state SHOWN)

## Operation
- Stage A (cycle t): in = i_de & X0<=i_x<X0+SPR_W & Y0<=i_y<Y0+SPR_H. col = i_x-X0 (9 b), row = i_y-Y0 (4 b).
- o_rom_addr <= in ? row*SPR_W + col : o_rom_addr (held when outside the sprite). Max is 11*356+355 = 4271, so 13 bits with no overflow. The multiply is a constant multiply, implemented shift-add.
- The vis flag is registered alongside the address: in & (col < reveal_cols). It is delayed one more stage to meet i_rom_data.
- Stage C: o_pixel <= i_rom_data. o_hit <= vis_d2 & (i_rom_data != TRANSP_KEY). When vis_d2 = 0, o_pixel <= 0.
- FSM states:
  - IDLE: reveal_cols = 0, nothing visible. i_start -> REVEAL.
  - REVEAL: on i_frame_tick, reveal_cols <= min(reveal_cols + COLS_PER_FRAME, SPR_W). When the updated value equals SPR_W -> SHOWN.
  - SHOWN: reveal_cols = SPR_W, o_done = 1. i_start -> REVEAL with reveal_cols <= 0.
- i_start in REVEAL restarts: reveal_cols <= 0, state stays REVEAL.
- i_start and i_frame_tick in the same cycle: start wins, reveal_cols <= 0, no increment that cycle.
- reveal_cols is 9 bits, saturating; it never exceeds SPR_W.

## Timing
- Latency from i_x/i_y/i_de to o_pixel/o_hit is exactly 3 cycles:
  - t+1: o_rom_addr valid
  - t+2: i_rom_data valid
  - t+3: outputs registered
- A reveal_cols change takes effect for scan positions sampled on the cycle after the update.
- Reset values: o_rom_addr=0, o_pixel=0, o_hit=0, o_done=0, state=IDLE, reveal_cols=0, all pipeline vis flags=0.
- Reset asserted mid-reveal or mid-line: on the next edge everything holds reset values. o_hit stays 0 until 3 cycles after the first in-sprite position after release and i_start.
- Full reveal at defaults takes ceil(356/4) = 89 frame ticks after i_start.

## Configuration
- NAME_REVEAL_EN defined: the reveal animation works as above.
- NAME_REVEAL_EN undefined: the FSM and counter are compiled out. i_start goes IDLE -> SHOWN in one cycle with reveal_cols = SPR_W. o_done rises the cycle after i_start. i_frame_tick is ignored.

## Structure
- Shared package holds:
  - SPR_W, SPR_H, ROM_AW = 13, ROM depth 4272
  - TRANSP_KEY default
  - FSM state encoding IDLE/REVEAL/SHOWN (2 b)
- One sub-module: name_reveal_ctrl. It holds the FSM and saturating reveal_cols counter. Inputs: i_clk2, i_rst, i_start, i_frame_tick. Outputs: reveal_cols, o_done. It is instantiated only under NAME_REVEAL_EN.
- The address/alignment pipeline stays in the top module.

## Test plan
- Reset then i_start, 89 frame ticks, bench ROM model with addr-echo data -> after tick 88 o_done=0; after tick 89 o_done=1 and reveal_cols=356.
- SHOWN state; scan (x=142,y=60), (497,71), (498,60), (141,60) -> o_rom_addr 0, 4271, held, held; o_hit 1,1,0,0 exactly 3 cycles later.
- SHOWN state; ROM word = 8'h00 at an in-sprite address -> o_hit=0 and o_pixel=0. Word 8'h3C -> o_hit=1, o_pixel=8'h3C.
- REVEAL after 10 ticks (reveal_cols=40); scan x=181 then x=182 on row 60 -> o_hit 1 then 0.
- i_start and i_frame_tick in the same cycle during REVEAL -> reveal_cols=0 next cycle. Reset pulse mid-line -> all outputs 0 next edge, state IDLE.
- NAME_REVEAL_EN undefined: i_start -> o_done=1 next cycle. Full sprite visible. Frame ticks have no effect.
